aes128_round_sequencer: RTL and testbench
=========================================

Name: aes128_round_sequencer

Overview:
Iterative AES-128 encryption engine. It owns a single round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and sequences it over rounds 0..10, one round per clock. Round keys come from an external round-key store through a registered read port. Plaintext input and ciphertext output each use a valid/ready handshake, so the block sits between the block-mode wrapper and the key-expansion RAM.

Parameters:
NR, 10, number of rounds; fixed for AES-128, and other values are unsupported.
KW, 128, round-key and block width in bits.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  pt is valid.
in_ready  out  1  the block can accept pt.
pt  in  128  plaintext. Byte 0 is pt[127:120]; the state is column-major, as in FIPS-197.
out_valid  out  1  ct is valid.
out_ready  in  1  downstream accepts ct.
ct  out  128  ciphertext.
rk_addr  out  4  round-key index 0..10 sent to the key store.
rk_data  in  128  round key; returns the key at the rk_addr presented on the previous cycle (1-cycle read latency).
busy  out  1  high in ROUND and DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - ct=0, rk_addr=0, round counter rnd=0, internal state register cleared.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1 and rk_addr held at 0, so rk_data=k0.
  - On in_valid&&in_ready: st <= pt ^ rk_data (round 0), rnd <= 1, rk_addr <= 1, go to ROUND.
- ROUND, rnd=r in 1..9:
  - st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk_data, where rk_data=k_r.
  - rnd <= r+1; rk_addr <= r+1.
- ROUND, rnd=10:
  - ct <= ShiftRows(SubBytes(st)) ^ rk_data (no MixColumns).
  - out_valid <= 1, rk_addr <= 0, rnd <= 0, go to DONE.
- DONE:
  - ct held stable and out_valid=1 until out_ready.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
  - rk_addr is already 0 here, so rk_data=k0 on the first IDLE cycle.
- Latency: out_valid rises 11 cycles after the accept edge. Minimum issue interval is 12 cycles (accept, 10 rounds, one DONE cycle with out_ready=1).
- in_ready=0 in ROUND and DONE. in_valid and pt are ignored there; pt is sampled only on the accept edge.
- in_valid deasserted in IDLE: no state change.
- out_ready asserted outside DONE: no effect.
- out_ready held high: DONE lasts exactly one cycle.
- rst mid-operation (ROUND or DONE): immediate return to reset values; the partial block is discarded and no out_valid is produced.
- SubBytes uses 16 parallel combinational S-box instances.
- MixColumns uses GF(2^8) xtime with polynomial 0x11B.
- All XORs are 128-bit; no other arithmetic beyond the 4-bit rnd counter. rnd never exceeds 10 and never wraps.

Optional Feature:
Macro AES_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 at an edge in ROUND or DONE: go to state FLUSH; out_valid <= 0, rk_addr <= 0, rnd <= 0, st and ct cleared.
  - FLUSH lasts one cycle with in_ready=0 and busy=1, letting rk_data return to k0. Then go to IDLE.
  - abort in IDLE is ignored.
  - rst takes priority over abort.
- Undefined: no abort port, no FLUSH state; behaviour exactly as above.

Test Plan:
1. FIPS-197 C.1: key-store model loaded with expansion of 000102030405060708090a0b0c0d0e0f; pt=00112233445566778899aabbccddeeff -> out_valid 11 cycles after accept, ct=69c4e0d86a7b0430d8cdb78070b4c55a, rk_addr sequence 1..10 then 0.
2. FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 -> ct=3925841d02dc09fbdc118597196a0b32.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> ct stable, in_ready=0 throughout, and a changing pt on in_valid is ignored. Release -> IDLE next cycle.
4. Back-to-back: in_valid and out_ready held high, two blocks (tests 1 and 2) -> accepts 12 cycles apart, both ct values correct and in order.
5. Reset at rnd=5 -> next cycle in_ready=1, out_valid=0, rk_addr=0, ct=0. The following block still encrypts correctly (C.1 value).
6. With AES_SEQ_ABORT_EN: abort at rnd=3 -> one FLUSH cycle (in_ready=0, busy=1), then IDLE, no out_valid, and the next block gives the correct ct.

Source files
------------

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption engine: one round per clock over rounds 0..10, with round keys
// fetched from an external key store. Optional abort/flush path enabled by AES_SEQ_ABORT_EN.
module aes128_round_sequencer #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [KW-1:0] pt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [KW-1:0] ct,
    output logic [3:0]    rk_addr,
    input  logic [KW-1:0] rk_data,
`ifdef AES_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy
);

`ifdef AES_SEQ_ABORT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2, FLUSH = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;
`endif

    localparam logic [3:0] LAST_RND = 4'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            acc = b[i] ? (acc ^ sh) : acc;
            sh  = xtime(sh);
        end
        return acc;
    endfunction

    // S-box computed algebraically: multiplicative inverse as x^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte n sits at [127-8n -: 8], row n%4, column n/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_t        state_r, state_nxt_s;
    logic [3:0]    rnd_r, rnd_nxt_s;
    logic [KW-1:0] st_r, st_nxt_s;
    logic [KW-1:0] ct_r, ct_nxt_s;
    logic [3:0]    rk_addr_r, rk_addr_nxt_s;
    logic          out_valid_r, out_valid_nxt_s;
    logic          in_ready_r, busy_r;
    logic [KW-1:0] sb_s, round_s, final_s;

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        assign sb_s[8*g +: 8] = sbox(st_r[8*g +: 8]);
    end

    assign round_s = mix_columns(shift_rows(sb_s)) ^ rk_data;
    assign final_s = shift_rows(sb_s) ^ rk_data;

    // Next-state and datapath update selection.
    always_comb begin
        state_nxt_s     = state_r;
        rnd_nxt_s       = rnd_r;
        st_nxt_s        = st_r;
        ct_nxt_s        = ct_r;
        rk_addr_nxt_s   = rk_addr_r;
        out_valid_nxt_s = out_valid_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    st_nxt_s      = pt ^ rk_data;
                    rnd_nxt_s     = 4'd1;
                    rk_addr_nxt_s = 4'd1;
                    state_nxt_s   = ROUND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ROUND: begin
                if (rnd_r == LAST_RND) begin
                    ct_nxt_s        = final_s;
                    out_valid_nxt_s = 1'b1;
                    rk_addr_nxt_s   = 4'd0;
                    rnd_nxt_s       = 4'd0;
                    state_nxt_s     = DONE;
                end else begin
                    st_nxt_s      = round_s;
                    rnd_nxt_s     = rnd_r + 4'd1;
                    rk_addr_nxt_s = rnd_r + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
`ifdef AES_SEQ_ABORT_EN
            FLUSH: begin
                state_nxt_s = IDLE;
            end
`endif
            default: begin
                state_nxt_s     = IDLE;
                rnd_nxt_s       = 4'd0;
                rk_addr_nxt_s   = 4'd0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
`ifdef AES_SEQ_ABORT_EN
        // Abort discards the block in flight and spends one cycle letting rk_data return to k0.
        if (abort && (state_r == ROUND || state_r == DONE)) begin
            state_nxt_s     = FLUSH;
            out_valid_nxt_s = 1'b0;
            rk_addr_nxt_s   = 4'd0;
            rnd_nxt_s       = 4'd0;
            st_nxt_s        = '0;
            ct_nxt_s        = '0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
`endif
    end

    // State and registered outputs; handshake flags are derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rnd_r       <= 4'd0;
            st_r        <= '0;
            ct_r        <= '0;
            rk_addr_r   <= 4'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rnd_r       <= rnd_nxt_s;
            st_r        <= st_nxt_s;
            ct_r        <= ct_nxt_s;
            rk_addr_r   <= rk_addr_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign ct        = ct_r;
    assign rk_addr   = rk_addr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Directed bench for aes128_round_sequencer using FIPS-197 vectors; the abort test is built
// only when AES_SEQ_ABORT_EN is defined.
module tb_aes128_round_sequencer;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [127:0] KEY_A [11] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5};
    localparam logic [127:0] KEY_B [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    logic         clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] pt, ct, rk_data;
    logic [3:0]   rk_addr;
`ifdef AES_SEQ_ABORT_EN
    logic         abort;
`endif

    logic [127:0] key_mem [0:15];
    int           errors, checks, cyc;
    int           accq[$];
    logic [127:0] ctq[$];

    aes128_round_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pt(pt),
        .out_valid(out_valid), .out_ready(out_ready), .ct(ct), .rk_addr(rk_addr),
        .rk_data(rk_data),
`ifdef AES_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy));

    // Key store: the read register is the sequencer's rk_addr register, so the array lookup is direct.
    assign rk_data = key_mem[rk_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log accept edges and delivered ciphertexts.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) accq.push_back(cyc);
        if (!rst && out_valid && out_ready) ctq.push_back(ct);
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input bit sel);
        for (int i = 0; i < 16; i++) key_mem[i] = 128'h0;
        for (int i = 0; i < 11; i++) key_mem[i] = sel ? KEY_B[i] : KEY_A[i];
    endtask

    task automatic issue(input logic [127:0] p);
        int g;
        g = 0;
        while (!in_ready && g < 40) begin @(negedge clk); g++; end
        pt = p;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // n counts edges from the accept edge inclusive.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 30) begin @(negedge clk); n++; end
    endtask

    initial begin
        int n;
        int gap;
        errors = 0; checks = 0; cyc = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt = 128'h0;
`ifdef AES_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        load_key(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 128'd1);
        chk("rst_out_valid", out_valid, 128'd0);
        chk("rst_busy", busy, 128'd0);
        chk("rst_ct", ct, 128'h0);
        chk("rst_rk_addr", rk_addr, 128'd0);
        repeat (2) @(negedge clk);
        chk("idle_hold_in_ready", in_ready, 128'd1);

        // Test 1: FIPS-197 C.1 with rk_addr sequence.
        out_ready = 1'b1;
        issue(PT1);
        chk("t1_rk_addr1", rk_addr, 128'd1);
        chk("t1_in_ready_busy", {in_ready, busy}, 128'b01);
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("t1_rk_addr%0d", k), rk_addr, 128'(k));
        end
        @(negedge clk);
        chk("t1_out_valid_at_11", out_valid, 128'd1);
        chk("t1_rk_addr_back0", rk_addr, 128'd0);
        chk("t1_ct", ct, CT1);
        @(negedge clk);
        chk("t1_idle_after_done", {in_ready, out_valid, busy}, 128'b100);

        // Test 2: FIPS-197 Appendix B.
        load_key(1'b1);
        issue(PT2);
        wait_out(n);
        chk("t2_latency", 128'(n), 128'd11);
        chk("t2_ct", ct, CT2);

        // Test 3: backpressure with changing pt on in_valid.
        @(negedge clk);
        out_ready = 1'b0;
        load_key(1'b0);
        issue(PT1);
        wait_out(n);
        chk("t3_latency", 128'(n), 128'd11);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            pt = {4{$urandom}};
            @(negedge clk);
            chk("t3_ct_stable", ct, CT1);
            chk("t3_held", {out_valid, in_ready, busy}, 128'b101);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_idle", {out_valid, in_ready, busy}, 128'b010);

        // Test 4: back-to-back blocks with in_valid and out_ready held high.
        accq.delete(); ctq.delete();
        load_key(1'b0);
        pt = PT1; in_valid = 1'b1;
        n = 0;
        while (ctq.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
            if (accq.size() >= 1) pt = PT2;
            if (out_valid && ctq.size() == 0) load_key(1'b1);
        end
        in_valid = 1'b0;
        gap = (accq.size() >= 2) ? accq[1] - accq[0] : -1;
        chk("t4_accepts", 128'(accq.size()), 128'd2);
        chk("t4_gap", 128'(gap), 128'd12);
        chk("t4_ct0", (ctq.size() >= 1) ? ctq[0] : 128'h0, CT1);
        chk("t4_ct1", (ctq.size() >= 2) ? ctq[1] : 128'h0, CT2);

        // Test 5: reset at rnd=5 discards the block.
        @(negedge clk);
        ctq.delete();
        load_key(1'b0);
        issue(PT1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_after_rst", {in_ready, out_valid, busy}, 128'b100);
        chk("t5_rk_addr", rk_addr, 128'd0);
        chk("t5_ct", ct, 128'h0);
        issue(PT1);
        wait_out(n);
        chk("t5_latency", 128'(n), 128'd11);
        chk("t5_ct_next", ct, CT1);
        @(negedge clk);
        chk("t5_one_output", 128'(ctq.size()), 128'd1);

`ifdef AES_SEQ_ABORT_EN
        // Test 6: abort at rnd=3.
        ctq.delete();
        issue(PT1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_flush", {in_ready, busy, out_valid}, 128'b010);
        @(negedge clk);
        chk("t6_idle", {in_ready, busy, out_valid}, 128'b100);
        issue(PT1);
        wait_out(n);
        chk("t6_ct_next", ct, CT1);
        @(negedge clk);
        chk("t6_one_output", 128'(ctq.size()), 128'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
